// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, serializer frame length, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int BYTE_W            = 8;
    // One 8N1 frame on the attached serializer, in core clock cycles.
    localparam int UART_FRAME_CYCLES = 153;

    typedef enum logic [2:0] {
        ST_FLUSH     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping modulo N_REQ.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to act on the grant.
//
// Ports:
//   req_i     request vector
//   ptr_i     index with highest priority this cycle
//   gnt_o     one-hot grant (all zero when nothing requests)
//   gnt_idx_o index of the granted requester
//   any_o     at least one request is set
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = '0;
        // Walk ptr, ptr+1, ... and keep the first hit only.
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDX_W'((int'(ptr_i) + k) % N_REQ);
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among N_REQ byte producers with round-robin grant and per-requester done pulses.
// Latency: valid->ack 1 cycle, ack cycle drives the single tx_ena pulse, done the cycle after tx_sent is seen high.
// Backpressure: requesters hold req_valid until req_ack; only one frame is in flight, others wait in round-robin order.
//
// Ports:
//   clk, reset         core clock, synchronous active-high reset
//   req_valid/req_data per-requester byte offer (byte i at [8i+7:8i])
//   req_ack/req_done   one-cycle pulses: byte captured / byte fully shifted out
//   busy               high in every state except IDLE
//   tx_data/tx_ena     to the serializer's data_transmit/ena; tx_sent from its sent output
//   tx_err             watchdog abort pulse
// Optional: define UART_ARB_TIMEOUT_EN to bound each wait state by TIMEOUT cycles; otherwise tx_err is 0.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int FLUSH_CYCLES = 160,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        req_ack,
    output logic [N_REQ-1:0]        req_done,
    output logic                    busy,
    output logic [BYTE_W-1:0]       tx_data,
    output logic                    tx_ena,
    input  logic                    tx_sent,
    output logic                    tx_err
);

    localparam int IDX_W   = $clog2(N_REQ);
    // One counter serves both the post-reset flush and the optional watchdog.
    localparam int CNT_MAX = (FLUSH_CYCLES > TIMEOUT) ? FLUSH_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    arb_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [IDX_W-1:0]   gidx_q;
    logic [BYTE_W-1:0]  tx_data_q;
    logic               tx_ena_q;
    logic [N_REQ-1:0]   req_ack_q;
    logic [N_REQ-1:0]   req_done_q;

    logic [N_REQ-1:0]   gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    always_comb begin
        ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic tx_err_q;
    assign tx_err = tx_err_q;
`else
    assign tx_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FLUSH;
            cnt_q      <= '0;
            ptr_q      <= '0;
            gidx_q     <= '0;
            tx_data_q  <= '0;
            tx_ena_q   <= 1'b0;
            req_ack_q  <= '0;
            req_done_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            tx_err_q   <= 1'b0;
`endif
        end else begin
            // All handshake outputs are single-cycle pulses.
            req_ack_q  <= '0;
            req_done_q <= '0;
            tx_ena_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            tx_err_q   <= 1'b0;
`endif
            case (state_q)
                // tx_sent is not looked at here: the serializer is not reset and may still be mid-frame.
                ST_FLUSH: begin
                    if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (gnt_any) begin
                        tx_data_q <= req_data[gnt_idx*BYTE_W +: BYTE_W];
                        req_ack_q <= gnt;
                        gidx_q    <= gnt_idx;
                        ptr_q     <= ptr_d;
                        // Registered here so the enable is high exactly during LAUNCH.
                        tx_ena_q  <= 1'b1;
                        state_q   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!tx_sent) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_HIGH;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        tx_err_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_FLUSH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                ST_WAIT_HIGH: begin
                    if (tx_sent) begin
                        req_done_q <= {{(N_REQ-1){1'b0}}, 1'b1} << gidx_q;
                        state_q    <= ST_IDLE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        tx_err_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_FLUSH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_FLUSH;
                end
            endcase
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign tx_data  = tx_data_q;
    assign tx_ena   = tx_ena_q;
    assign req_ack  = req_ack_q;
    assign req_done = req_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural serializer and an ack/done scoreboard.
// Latency: n/a.
// Backpressure: requesters hold valid until ack, as a real producer would.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ack, req_done;
    logic        busy, tx_ena, tx_sent, tx_err;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .FLUSH_CYCLES(160), .TIMEOUT(255)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .req_done  (req_done),
        .busy      (busy),
        .tx_data   (tx_data),
        .tx_ena    (tx_ena),
        .tx_sent   (tx_sent),
        .tx_err    (tx_err)
    );

    // Serializer model: an enable while idle starts a 153-cycle frame with sent low.
    int         frame_cnt = 0;
    logic       stuck = 1'b0;
    logic       track = 1'b0;
    logic [7:0] frame_byte = '0;
    assign tx_sent = stuck | (frame_cnt == 0);

    always @(posedge clk) begin
        if (frame_cnt != 0) frame_cnt <= frame_cnt - 1;
        else if (tx_ena) begin
            frame_cnt  <= 153;
            frame_byte <= tx_data;
        end
        if (reset) track <= 1'b0;
        else if (tx_ena && frame_cnt == 0) track <= 1'b1;
        else if (frame_cnt == 1) track <= 1'b0;
    end

    typedef struct packed { logic [1:0] idx; logic [7:0] dat; } exp_t;
    exp_t       exp_q[$];
    logic [1:0] fly_q[$];
    int         errors = 0;
    int         checks = 0;
    int         ack_cnt[4] = '{0, 0, 0, 0};
    logic       ena_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (req_ack != 0) begin
                for (int i = 0; i < 4; i++) if (req_ack[i]) ack_cnt[i]++;
                if (exp_q.size() == 0) chk("ack_unexpected", {28'd0, req_ack}, 32'd0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_idx", {28'd0, req_ack}, 32'd1 << e.idx);
                    chk("ena_with_ack", {31'd0, tx_ena}, 32'd1);
                    chk("tx_data", {24'd0, tx_data}, {24'd0, e.dat});
                    fly_q.push_back(e.idx);
                end
            end
            if (req_done != 0) begin
                if (fly_q.size() == 0) chk("done_unexpected", {28'd0, req_done}, 32'd0);
                else chk("done_idx", {28'd0, req_done}, 32'd1 << fly_q.pop_front());
            end
            if (tx_ena) chk("ena_gap", {31'd0, ena_prev}, 32'd0);
            if (track && busy !== 1'b1) chk("busy_mid_frame", {31'd0, busy}, 32'd1);
            if (track && tx_data !== frame_byte) chk("tx_data_stable", {24'd0, tx_data}, {24'd0, frame_byte});
        end
        ena_prev = tx_ena;
    end

    task automatic measure_flush(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (busy === 1'b1 && n < 1000);
    endtask

    task automatic wait_done(input string tag, input logic [3:0] mask, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (req_done == 0 && n < 400);
        chk(tag, {28'd0, req_done}, {28'd0, mask});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n, got, a3_before, dn;
        logic reloaded;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", {28'd0, req_ack}, 32'd0);
        chk("rst_done", {28'd0, req_done}, 32'd0);
        chk("rst_ena", {31'd0, tx_ena}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_err", {31'd0, tx_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        measure_flush(n);
        chk("flush_len", n, 160);

        // Single byte from requester 0
        req_data[7:0] = 8'h41; req_valid = 4'b0001;
        exp_q.push_back('{idx: 2'd0, dat: 8'h41});
        @(negedge clk);
        chk("t1_ack_latency", {28'd0, req_ack}, 32'h1);
        chk("t1_ena", {31'd0, tx_ena}, 32'd1);
        req_valid = 4'b0000;
        wait_done("t1_done", 4'b0001, n);
        chk("t1_done_latency", n, 155);
        chk("t1_sent_at_done", {31'd0, tx_sent}, 32'd1);

        // Reset 60 cycles into a frame from requester 1 (pointer is 1 now)
        req_data[15:8] = 8'h55; req_valid = 4'b0010;
        exp_q.push_back('{idx: 2'd1, dat: 8'h55});
        @(negedge clk);
        chk("t4_ack1", {28'd0, req_ack}, 32'h2);
        req_valid = 4'b0000;
        repeat (59) @(negedge clk);
        reset = 1'b1;
        fly_q.delete();
        @(negedge clk);
        chk("t4_rst_busy", {31'd0, busy}, 32'd1);
        chk("t4_rst_done", {28'd0, req_done}, 32'd0);
        chk("t4_rst_ena", {31'd0, tx_ena}, 32'd0);
        reset = 1'b0;
        measure_flush(n);
        chk("t4_flush_len", n, 160);

        // All four requesting; requester 0 re-queues a second byte after its ack
        req_data = 32'h4030_2010; req_valid = 4'b1111;
        exp_q.push_back('{idx: 2'd0, dat: 8'h10});
        exp_q.push_back('{idx: 2'd1, dat: 8'h20});
        exp_q.push_back('{idx: 2'd2, dat: 8'h30});
        exp_q.push_back('{idx: 2'd3, dat: 8'h40});
        exp_q.push_back('{idx: 2'd0, dat: 8'h50});
        got = 0; reloaded = 1'b0; n = 0;
        while (got < 5 && n < 2000) begin
            @(negedge clk); n++;
            for (int i = 0; i < 4; i++) begin
                if (req_ack[i]) begin
                    got++;
                    if (i == 0 && !reloaded) begin
                        req_data[7:0] = 8'h50;
                        reloaded = 1'b1;
                    end else req_valid[i] = 1'b0;
                end
            end
        end
        chk("rr_all_served", got, 5);
        wait_done("rr_last_done", 4'b0001, n);

        // Requesters 2 and 0 arrive while 1 is on the wire; pointer lands on 2
        req_data[15:8] = 8'h61; req_valid = 4'b0010;
        exp_q.push_back('{idx: 2'd1, dat: 8'h61});
        @(negedge clk);
        chk("t3_ack1", {28'd0, req_ack}, 32'h2);
        req_valid[1] = 1'b0;
        repeat (20) @(negedge clk);
        req_data[23:16] = 8'h72; req_data[7:0] = 8'h03;
        req_valid[2] = 1'b1; req_valid[0] = 1'b1;
        exp_q.push_back('{idx: 2'd2, dat: 8'h72});
        exp_q.push_back('{idx: 2'd0, dat: 8'h03});
        wait_done("t3_done1", 4'b0010, n);
        @(negedge clk);
        chk("t3_grant2_next", {28'd0, req_ack}, 32'h4);
        req_valid[2] = 1'b0;
        wait_done("t3_done2", 4'b0100, n);
        @(negedge clk);
        chk("t3_grant0_next", {28'd0, req_ack}, 32'h1);
        req_valid[0] = 1'b0;

        // Requester 3 pulses and withdraws while requester 0 owns the bus
        a3_before = ack_cnt[3];
        repeat (10) @(negedge clk);
        req_data[31:24] = 8'hEE; req_valid[3] = 1'b1;
        repeat (3) @(negedge clk);
        req_valid[3] = 1'b0;
        wait_done("t5_done0", 4'b0001, n);
        repeat (200) @(negedge clk);
        chk("t5_no_ack3", ack_cnt[3], a3_before);
        chk("t5_queue_empty", exp_q.size(), 0);
        chk("t5_idle", {31'd0, busy}, 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
        // Serializer never drops sent: watchdog must abort into FLUSH
        stuck = 1'b1;
        req_data[7:0] = 8'h99; req_valid = 4'b0001;
        exp_q.push_back('{idx: 2'd0, dat: 8'h99});
        @(negedge clk);
        chk("to_ack0", {28'd0, req_ack}, 32'h1);
        req_valid = 4'b0000;
        n = 0; dn = 0;
        do begin
            @(negedge clk); n++;
            if (req_done != 0) dn++;
        end while (tx_err !== 1'b1 && n < 600);
        chk("to_err_delay", n, 256);
        chk("to_no_done", dn, 0);
        fly_q.delete();
        @(negedge clk);
        chk("to_err_pulse", {31'd0, tx_err}, 32'd0);
        chk("to_flush_busy", {31'd0, busy}, 32'd1);
        stuck = 1'b0;
        repeat (200) @(negedge clk);
        chk("to_recovered_idle", {31'd0, busy}, 32'd0);
`else
        chk("tx_err_tied", {31'd0, tx_err}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
